// File: rtl/fft_input_loader.sv
// Loads 32-sample frames from a valid/ready stream into the FFT sample RAM (port A).
// Define FFT_LOADER_BITREV_EN for bit-reversed write addresses; otherwise natural order.
module fft_input_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              frame_done,
  input  logic              frame_ack,
  output logic              busy
);

  typedef enum logic {LOAD, FULL} state_e;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e              state_q;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   wr_addr;
  logic                ram_en_q, frame_done_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic                accept;

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == FULL);
  assign accept   = in_valid && in_ready;
  assign count_d  = count_q + ADDR_W'(1);

`ifdef FFT_LOADER_BITREV_EN
  for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
    assign wr_addr[i] = count_q[ADDR_W-1-i];
  end
`else
  assign wr_addr = count_q;
`endif

  // frame_done fires on the edge after the final write strobe, once the RAM
  // has captured the last sample; ram_en_q is only high in FULL right after entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      count_q      <= '0;
      ram_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ram_en_q     <= accept;
      frame_done_q <= (state_q == FULL) && ram_en_q;
      if (accept) begin
        ram_addr_q <= wr_addr;
        ram_din_q  <= in_data;
        count_q    <= count_d;
      end
      case (state_q)
        LOAD: if (accept && count_q == LAST) state_q <= FULL;
        FULL: if (frame_ack) state_q <= LOAD;
        default: state_q <= LOAD;
      endcase
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: streaming, backpressure, gaps, ack timing, mid-frame reset.
module tb_fft_input_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ram_en;
  logic [4:0]  ram_addr;
  logic [15:0] ram_din;
  logic        frame_done;
  logic        frame_ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fft_input_loader #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_din(ram_din),
    .frame_done(frame_done), .frame_ack(frame_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  addr;
  } vec_t;

  // hand-computed 5-bit bit reversal of 0..31
  localparam int BR[32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                            1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  vec_t vt[32];
  int   nwr;

  function automatic logic [4:0] ea(input int k);
`ifdef FFT_LOADER_BITREV_EN
    return 5'(BR[k]);
`else
    return 5'(k);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      vt[k].data = 16'h1000 + 16'(k);
      vt[k].addr = ea(k);
    end
    in_valid = 1'b0; in_data = '0; frame_ack = 1'b0;

    // reset state
    #12;
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 1);
    #6 rst_n = 1'b1;

    // 1: continuous stream, table-driven
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_data = vt[k].data;
      if (k == 0) chk("s1_ready_first", 32'(in_ready), 1);
      step();
      chk($sformatf("s1_en[%0d]", k), 32'(ram_en), 1);
      chk($sformatf("s1_addr[%0d]", k), 32'(ram_addr), 32'(vt[k].addr));
      chk($sformatf("s1_din[%0d]", k), 32'(ram_din), 32'(vt[k].data));
      chk($sformatf("s1_done[%0d]", k), 32'(frame_done), 0);
    end
    in_data = 16'hBEEF;
    chk("s1_busy", 32'(busy), 1);
    chk("s1_ready_low", 32'(in_ready), 0);
    step();
    chk("s1_en_off", 32'(ram_en), 0);
    chk("s1_done_pulse", 32'(frame_done), 1);

    // 2: backpressure while FULL
    for (int i = 0; i < 10; i++) begin
      step();
      chk("s2_en", 32'(ram_en), 0);
      chk("s2_done", 32'(frame_done), 0);
      chk("s2_ready", 32'(in_ready), 0);
      chk("s2_din_hold", 32'(ram_din), 32'h101F);
    end
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("s2_ready_after_ack", 32'(in_ready), 1);
    chk("s2_busy_after_ack", 32'(busy), 0);
    in_valid = 1'b1; in_data = 16'h2000;
    step();
    chk("s2_first_en", 32'(ram_en), 1);
    chk("s2_first_addr", 32'(ram_addr), 0);
    chk("s2_first_din", 32'(ram_din), 32'h2000);

    // 3: gappy input 1,0,0,1,...
    nwr = 1;
    for (int k = 1; k < 32; k++) begin
      in_valid = 1'b0;
      for (int g = 0; g < 2; g++) begin
        step();
        chk("s3_gap_en", 32'(ram_en), 0);
        chk("s3_gap_addr_hold", 32'(ram_addr), 32'(ea(k - 1)));
      end
      in_valid = 1'b1; in_data = 16'h2000 + 16'(k);
      step();
      if (ram_en) nwr++;
      chk($sformatf("s3_addr[%0d]", k), 32'(ram_addr), 32'(ea(k)));
      chk($sformatf("s3_din[%0d]", k), 32'(ram_din), 32'h2000 + 32'(k));
    end
    chk("s3_writes", 32'(nwr), 32);
    in_valid = 1'b0;
    step();
    chk("s3_done_pulse", 32'(frame_done), 1);

    // 4a: ack in the same cycle as frame_done
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("s4_same_ack_busy", 32'(busy), 0);
    chk("s4_same_ack_ready", 32'(in_ready), 1);
    chk("s4_same_ack_done", 32'(frame_done), 0);

    // 4b: ack during LOAD is ignored
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_data = 16'h3000 + 16'(k);
      frame_ack = (k == 10);
      step();
      frame_ack = 1'b0;
      chk($sformatf("s4_en[%0d]", k), 32'(ram_en), 1);
      chk($sformatf("s4_addr[%0d]", k), 32'(ram_addr), 32'(ea(k)));
      chk($sformatf("s4_din[%0d]", k), 32'(ram_din), 32'h3000 + 32'(k));
      if (k == 10) begin
        chk("s4_ack_load_busy", 32'(busy), 0);
        in_valid = 1'b0; frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk("s4_ack_idle_busy", 32'(busy), 0);
        chk("s4_ack_idle_ready", 32'(in_ready), 1);
        chk("s4_ack_idle_en", 32'(ram_en), 0);
      end
    end
    in_valid = 1'b0;
    step();
    chk("s4_done_pulse", 32'(frame_done), 1);
    step();
    chk("s4_done_clear", 32'(frame_done), 0);
    chk("s4_busy_hold", 32'(busy), 1);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("s4_released", 32'(in_ready), 1);

    // 5: asynchronous reset after 12 accepts
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1; in_data = 16'h4000 + 16'(k);
      step();
    end
    chk("s5_pre_en", 32'(ram_en), 1);
    chk("s5_pre_addr", 32'(ram_addr), 32'(ea(11)));
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("s5_rst_en", 32'(ram_en), 0);
    chk("s5_rst_addr", 32'(ram_addr), 0);
    chk("s5_rst_din", 32'(ram_din), 0);
    chk("s5_rst_done", 32'(frame_done), 0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1; in_data = 16'h5000 + 16'(k);
      step();
      chk($sformatf("s5_addr[%0d]", k), 32'(ram_addr), 32'(ea(k)));
      chk($sformatf("s5_din[%0d]", k), 32'(ram_din), 32'h5000 + 32'(k));
      chk($sformatf("s5_done[%0d]", k), 32'(frame_done), 0);
      if (k < 31) chk($sformatf("s5_busy[%0d]", k), 32'(busy), 0);
    end
    in_valid = 1'b0;
    chk("s5_busy_full", 32'(busy), 1);
    step();
    chk("s5_done_pulse", 32'(frame_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
